iter_multiplier: RTL

Multi-cycle shift-add multiplier that produces the `multRes` operand consumed by the ALU B-input select (ALUSrc = 3'b011) for MUL and, optionally, the MULH-family instructions. It sits in the execute stage beside the ALU. It accepts two 64-bit register operands on a one-cycle `start` pulse and returns the product a fixed number of cycles later. `busy` feeds the pipeline stall logic, so the stage holds until `done`.

---
 rtl/iter_multiplier_if.sv | 24 ++
 rtl/iter_multiplier.sv | 139 +++++++++++++
 2 files changed

// File: rtl/iter_multiplier_if.sv
// Request/response bundle between the execute stage and the iterative multiplier.
// The master issues operands with a start pulse; the slave returns busy/done/multRes.
interface iter_multiplier_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             high;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] multRes;

    modport master (
        output start, a, b, is_signed, high,
        input  busy, done, multRes
    );

    modport slave (
        input  start, a, b, is_signed, high,
        output busy, done, multRes
    );
endinterface

// File: rtl/iter_multiplier.sv
// Fixed-latency shift-add multiplier (WIDTH+1 edges from start to done).
// Define ITER_MULT_HIGH_EN to keep the full product and support high/signed results.
module iter_multiplier #(
    parameter int WIDTH = 64
) (
    input logic              clk,
    input logic              reset_n,
    iter_multiplier_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef ITER_MULT_HIGH_EN
    localparam int AW = 2 * WIDTH;
`else
    localparam int AW = WIDTH;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] mult_res_q, mult_res_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] addend;
    logic [AW-1:0]    acc_step;
    logic [WIDTH-1:0] result;

`ifdef ITER_MULT_HIGH_EN
    logic [WIDTH-1:0] b_q, b_d;
    logic             signed_q, signed_d;
    logic             high_q, high_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] hi_fix;
`else
    logic             unused_cfg;
    assign unused_cfg = bus.is_signed ^ bus.high;
`endif

    assign bus.busy    = (state_q == RUN);
    assign bus.done    = (state_q == DONE);
    assign bus.multRes = mult_res_q;

    always_comb begin
        addend = mplier_q[0] ? mcand_q : '0;
`ifdef ITER_MULT_HIGH_EN
        // Carry out of the upper half is kept and shifted back into the MSB.
        sum      = {1'b0, acc_q[AW-1:WIDTH]} + {1'b0, addend};
        acc_step = AW'({sum, acc_q[WIDTH-1:0]} >> 1);
        hi_fix   = acc_step[AW-1:WIDTH]
                 - (mcand_q[WIDTH-1] ? b_q : '0)
                 - (b_q[WIDTH-1] ? mcand_q : '0);
        if (!high_q)
            result = acc_step[WIDTH-1:0];
        else if (signed_q)
            result = hi_fix;
        else
            result = acc_step[AW-1:WIDTH];
`else
        // Low half only: shift the multiplicand left instead of the accumulator right.
        acc_step = acc_q + addend;
        result   = acc_step;
`endif
    end

    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        mult_res_d = mult_res_q;
`ifdef ITER_MULT_HIGH_EN
        b_d        = b_q;
        signed_d   = signed_q;
        high_d     = high_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE)
                    state_d = IDLE;
                if (bus.start) begin
                    mcand_d  = bus.a;
                    mplier_d = bus.b;
                    acc_d    = '0;
                    cnt_d    = CW'(WIDTH - 1);
                    state_d  = RUN;
`ifdef ITER_MULT_HIGH_EN
                    b_d      = bus.b;
                    signed_d = bus.is_signed;
                    high_d   = bus.high;
`endif
                end
            end
            RUN: begin
                acc_d    = acc_step;
                mplier_d = mplier_q >> 1;
`ifndef ITER_MULT_HIGH_EN
                mcand_d  = mcand_q << 1;
`endif
                if (cnt_q == '0) begin
                    mult_res_d = result;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            mult_res_q <= '0;
`ifdef ITER_MULT_HIGH_EN
            b_q        <= '0;
            signed_q   <= 1'b0;
            high_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            mult_res_q <= mult_res_d;
`ifdef ITER_MULT_HIGH_EN
            b_q        <= b_d;
            signed_q   <= signed_d;
            high_q     <= high_d;
`endif
        end
    end
endmodule
